// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampling UART receiver.
//
// Takes a one-clk sample_tick (16 per bit period), synchronises rxd, and
// majority-votes each bit from oversamples 7, 8 and 9. Received characters
// are presented on a valid/ready interface with per-character parity and
// frame error flags. A sticky overrun flag records any dropped character.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   sample_tick       oversample enable, one clk wide
//   rxd               asynchronous serial input, idle high
//   parity_en         parity bit follows the data bits
//   parity_odd        odd (1) / even (0) parity
//   rx_data           received character (LSB first on the wire)
//   rx_valid/rx_ready character handshake
//   rx_parity_err     parity mismatch for the held character
//   rx_frame_err      stop bit sampled low for the held character
//   rx_overrun        sticky, a character was dropped; cleared by err_clr
//   err_clr           clears rx_overrun
//   rx_busy           receiver is inside a frame
module uart_rx #(
  parameter int DATA_BITS   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_tick,
  input  logic                 rxd,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_overrun,
  input  logic                 err_clr,
  output logic                 rx_busy
);

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------
  // Input synchroniser; preset high so reset never looks like a start bit
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxd_s;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
  end

  assign rxd_s = sync_q[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Frame state
  // ---------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shreg_q, shreg_d;
  logic                   armed_q, armed_d;
  logic                   perr_q, perr_d;
  logic                   pen_q, pen_d;
  logic                   podd_q, podd_d;
  logic                   smp7_q, smp8_q, smp9_q;

  // Completion strobe and frame error of the completing character
  logic                   done;
  logic                   ferr_new;

  // Third vote input: at cnt 9 the live sample is used so the stop bit can
  // complete on that tick; later in the bit the stored sample is used.
  logic                   smp9_eff;
  logic                   vote;

  assign smp9_eff = (cnt_q == 4'd9) ? rxd_s : smp9_q;
  assign vote     = (smp7_q & smp8_q) | (smp7_q & smp9_eff) | (smp8_q & smp9_eff);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shreg_q   <= '0;
      armed_q   <= 1'b0;
      perr_q    <= 1'b0;
      pen_q     <= 1'b0;
      podd_q    <= 1'b0;
      smp7_q    <= 1'b1;
      smp8_q    <= 1'b1;
      smp9_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shreg_q   <= shreg_d;
      armed_q   <= armed_d;
      perr_q    <= perr_d;
      pen_q     <= pen_d;
      podd_q    <= podd_d;
      if (sample_tick) begin
        if (cnt_q == 4'd7) smp7_q <= rxd_s;
        if (cnt_q == 4'd8) smp8_q <= rxd_s;
        if (cnt_q == 4'd9) smp9_q <= rxd_s;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    armed_d   = armed_q;
    perr_d    = perr_q;
    pen_d     = pen_q;
    podd_d    = podd_q;
    done      = 1'b0;
    ferr_new  = 1'b0;

    if (sample_tick) begin
      // Counter free-runs and wraps 15->0 across bit boundaries
      cnt_d = cnt_q + 4'd1;
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (rxd_s) begin
            armed_d = 1'b1;
          end else if (armed_q) begin
            // Detect tick is sample 0 of the start bit
            state_d   = S_START;
            cnt_d     = 4'd1;
            armed_d   = 1'b0;
            bit_idx_d = '0;
            perr_d    = 1'b0;
            pen_d     = parity_en;
            podd_d    = parity_odd;
          end
        end
        S_START: begin
          if (cnt_q == 4'd15) begin
            if (vote) begin
              state_d = S_IDLE;   // glitch, not a real start bit
            end else begin
              state_d   = S_DATA;
              bit_idx_d = '0;
            end
          end
        end
        S_DATA: begin
          if (cnt_q == 4'd15) begin
            shreg_d   = {vote, shreg_q[DATA_BITS-1:1]};
            bit_idx_d = bit_idx_q + BW'(1);
            if (bit_idx_q == LAST_BIT)
              state_d = pen_q ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          if (cnt_q == 4'd15) begin
            perr_d  = vote ^ (^shreg_q) ^ podd_q;
            state_d = S_STOP;
          end
        end
        S_STOP: begin
          // Finish mid-stop-bit so a following start edge is not missed
          if (cnt_q == 4'd9) begin
            done     = 1'b1;
            ferr_new = ~vote;
            // A low stop bit leaves us disarmed: a break yields one frame
            armed_d  = vote;
            state_d  = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Output holding register and handshake
  // ---------------------------------------------------------------------
  logic accept_new;
  logic overrun_set;

  assign accept_new  = done & (~rx_valid | rx_ready);
  assign overrun_set = done & rx_valid & ~rx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      if (accept_new) begin
        rx_data       <= shreg_q;
        rx_parity_err <= perr_q;
        rx_frame_err  <= ferr_new;
        rx_valid      <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end

      // New overrun wins over a simultaneous clear
      if (overrun_set)  rx_overrun <= 1'b1;
      else if (err_clr) rx_overrun <= 1'b0;
    end
  end

  assign rx_busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
// tb_uart_rx: directed and randomized checks of uart_rx against a
// frame-level reference (expected character, flags and completion tick
// derived from what was put on the line).
module tb_uart_rx;

  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_tick;
  logic          rxd = 1'b1;
  logic          parity_en = 1'b0;
  logic          parity_odd = 1'b0;
  logic [DB-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready = 1'b1;
  logic          rx_parity_err;
  logic          rx_frame_err;
  logic          rx_overrun;
  logic          err_clr = 1'b0;
  logic          rx_busy;

  int n_chk = 0;
  int n_err = 0;

  uart_rx #(.DATA_BITS(DB), .SYNC_STAGES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_tick  (sample_tick),
    .rxd          (rxd),
    .parity_en    (parity_en),
    .parity_odd   (parity_odd),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_parity_err(rx_parity_err),
    .rx_frame_err (rx_frame_err),
    .rx_overrun   (rx_overrun),
    .err_clr      (err_clr),
    .rx_busy      (rx_busy)
  );

  always #5 clk = ~clk;

  // One tick every 4 clk; tick_cnt = number of ticks seen so far
  logic [1:0] tdiv = '0;
  int         tick_cnt = 0;
  assign sample_tick = (tdiv == 2'd3);
  always @(posedge clk) begin
    tdiv <= tdiv + 2'd1;
    if (sample_tick) tick_cnt <= tick_cnt + 1;
  end

  // Every accepted character, with the tick count at acceptance
  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    int         tick;
  } rec_t;
  rec_t got[$];

  always @(negedge clk) begin : mon
    rec_t r;
    if (!rst && rx_valid && rx_ready) begin
      r.d    = rx_data;
      r.pe   = rx_parity_err;
      r.fe   = rx_frame_err;
      r.tick = tick_cnt;
      got.push_back(r);
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 1 ns after a ticking clk edge, so rxd changes well clear of it
  task automatic wait_tick();
    do @(posedge clk); while (!sample_tick);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) wait_tick();
  endtask

  // Start bit, data LSB first, optional parity, stop_ticks of stop bit.
  // det = tick index the receiver should treat as the detect tick.
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                            input logic stopb, input int stop_ticks, output int det);
    rxd = 1'b0;
    det = tick_cnt;
    repeat (16) wait_tick();
    for (int i = 0; i < DB; i++) begin
      rxd = d[i];
      repeat (16) wait_tick();
    end
    if (pen) begin
      rxd = pbit;
      repeat (16) wait_tick();
    end
    rxd = stopb;
    repeat (stop_ticks) wait_tick();
  endtask

  // Reference: completion on tick det+153 (8N1) or det+169 (with parity),
  // visible on the following clk, so tick_cnt then reads one more.
  function automatic int exp_tick(input int det, input logic pen);
    return det + (pen ? 170 : 154);
  endfunction

  function automatic logic exp_perr(input logic [7:0] d, input logic pen,
                                    input logic odd, input logic pbit);
    int ones = 0;
    for (int i = 0; i < DB; i++) ones += int'(d[i]);
    if (!pen) return 1'b0;
    // Total ones including parity bit must be even (even) or odd (odd)
    return ((ones + int'(pbit)) % 2) != int'(odd);
  endfunction

  task automatic expect_rec(input string tag, input logic [7:0] d, input logic pe,
                            input logic fe, input int tk);
    rec_t r;
    check({tag, "_count"}, got.size(), 1);
    if (got.size() > 0) begin
      r = got.pop_front();
      check({tag, "_data"}, r.d, d);
      check({tag, "_perr"}, r.pe, pe);
      check({tag, "_ferr"}, r.fe, fe);
      if (tk >= 0) check({tag, "_tick"}, r.tick, tk);
    end
    got.delete();
  endtask

  initial begin
    int det, d1, d2;
    logic [7:0] d;
    logic pen, odd, pbit, stopb;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", rx_valid, 0);
    check("rst_data", rx_data, 0);
    check("rst_perr", rx_parity_err, 0);
    check("rst_ferr", rx_frame_err, 0);
    check("rst_ovr", rx_overrun, 0);
    check("rst_busy", rx_busy, 0);
    rst = 1'b0;
    idle(4);

    // 8N1, 0xA5, exact completion timing
    send_frame(8'hA5, 0, 0, 1, 16, det);
    idle(2);
    expect_rec("a5", 8'hA5, 0, 0, exp_tick(det, 0));

    // 8E1 with a wrong parity bit, correct parity bit, then 8O1
    parity_en = 1'b1; parity_odd = 1'b0;
    send_frame(8'h3C, 1, 1, 1, 16, det);
    idle(2);
    expect_rec("e_bad", 8'h3C, 1, 0, exp_tick(det, 1));
    send_frame(8'h3C, 1, 0, 1, 16, det);
    idle(2);
    expect_rec("e_ok", 8'h3C, 0, 0, exp_tick(det, 1));
    parity_odd = 1'b1;
    send_frame(8'h3C, 1, 1, 1, 16, det);
    idle(2);
    expect_rec("o_ok", 8'h3C, 0, 0, exp_tick(det, 1));
    parity_en = 1'b0; parity_odd = 1'b0;

    // Glitch: 5 ticks low is rejected after sample 15 of the start bit
    rxd = 1'b0;
    repeat (5) wait_tick();
    rxd = 1'b1;
    repeat (10) wait_tick();
    check("glitch_busy", rx_busy, 1);
    wait_tick();
    check("glitch_idle", rx_busy, 0);
    idle(2);
    check("glitch_none", got.size(), 0);
    send_frame(8'h55, 0, 0, 1, 16, det);
    idle(2);
    expect_rec("g55", 8'h55, 0, 0, exp_tick(det, 0));

    // Break: low stop bit then 40 bit times low gives exactly one frame
    send_frame(8'h00, 0, 0, 0, 16, det);
    repeat (40 * 16 - 16) wait_tick();
    expect_rec("brk", 8'h00, 0, 1, exp_tick(det, 0));
    idle(4);
    send_frame(8'h81, 0, 0, 1, 16, det);
    idle(2);
    expect_rec("b81", 8'h81, 0, 0, exp_tick(det, 0));

    // Overrun: consumer stalled across two back-to-back frames
    rx_ready = 1'b0;
    send_frame(8'h11, 0, 0, 1, 16, d1);
    send_frame(8'h22, 0, 0, 1, 16, d2);
    idle(2);
    check("ovr_valid", rx_valid, 1);
    check("ovr_data", rx_data, 8'h11);
    check("ovr_flag", rx_overrun, 1);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    check("clr_flag", rx_overrun, 0);
    check("clr_valid", rx_valid, 1);
    wait_tick();
    // 0x33: ready only on its completion clk, so it replaces 0x11
    send_frame(8'h33, 0, 0, 1, 9, det);
    repeat (3) @(posedge clk);
    #1;
    rx_ready = 1'b1;
    wait_tick();
    rx_ready = 1'b0;
    expect_rec("held11", 8'h11, 0, 0, -1);
    check("rep_valid", rx_valid, 1);
    check("rep_data", rx_data, 8'h33);
    check("rep_ovr", rx_overrun, 0);
    repeat (6) wait_tick();
    idle(2);

    // Reset in the middle of data bit 3 of 0xF0 (held 0x33 still pending)
    rxd = 1'b0;
    repeat (16) wait_tick();
    for (int i = 0; i < 3; i++) repeat (16) wait_tick();
    repeat (8) wait_tick();
    check("mid_busy", rx_busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mrst_valid", rx_valid, 0);
    check("mrst_data", rx_data, 0);
    check("mrst_ovr", rx_overrun, 0);
    check("mrst_busy", rx_busy, 0);
    rst = 1'b0;
    rx_ready = 1'b1;
    idle(4);
    got.delete();
    send_frame(8'hF0, 0, 0, 1, 16, det);
    idle(2);
    expect_rec("f0", 8'hF0, 0, 0, exp_tick(det, 0));

    // Randomized frames
    for (int n = 0; n < 30; n++) begin
      d     = 8'($urandom);
      pen   = 1'($urandom);
      odd   = 1'($urandom);
      pbit  = 1'($urandom);
      stopb = ($urandom_range(0, 7) != 0);
      parity_en  = pen;
      parity_odd = odd;
      send_frame(d, pen, pbit, stopb, 16, det);
      idle($urandom_range(1, 20));
      expect_rec($sformatf("rnd%0d", n), d, exp_perr(d, pen, odd, pbit), ~stopb,
                 exp_tick(det, pen));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
